mpi_master: RTL and testbench
=============================

// Module: mpi_master
// PURPOSE
//  Initiator end of the MPI CPU bus. Turns a valid/ready command stream into
//  timed chip-select/strobe cycles toward an MPI register slave. Reads return
//  the sampled data on a one-cycle response. Used as an on-chip config loader
//  and as the bus driver in board-level loopback.
// PARAMETERS
//  SETUP_CYC   2  cycles cs/addr/rdwr valid before strobe (1..15)
//  STROBE_CYC  4  cycles mpi_en asserted (1..15)
//  HOLD_CYC    1  cycles cs/addr held after strobe release (1..15)
// PORTS
//  clk100m     in   1   single clock domain
//  rst         in   1   async reset, active-low
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   command accepted when valid&ready
//  cmd_rd      in   1   1=read, 0=write
//  cmd_addr    in   25  target address
//  cmd_wdata   in   16  write data
//  rsp_valid   out  1   one-cycle response pulse; no backpressure
//  rsp_rdata   out  16  read data; 0 for writes
//  rsp_err     out  1   write-verify mismatch (0 when feature is off)
//  mpi_cs      out  1   chip select, active-low
//  mpi_en      out  1   strobe, active-low
//  mpi_rdwr    out  1   1=read, 0=write
//  mpi_addr    out  25  bus address
//  mpi_dout    out  16  write data to slave
//  mpi_oe      out  1   data-bus drive enable (write cycles only)
//  mpi_din     in   16  read data from slave
// BEHAVIOUR
//  Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mpi_cs=1,
//   mpi_en=1, mpi_rdwr=1, mpi_addr=0, mpi_dout=0, mpi_oe=0. All outputs registered.
//  FSM: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE. One shared 4-bit phase counter.
//  Command accepted at edge T. SETUP occupies T+1..T+S: cs=0, addr/rdwr/dout
//   driven, oe=~cmd_rd. STROBE occupies the next E cycles with en=0. HOLD
//   occupies the next H cycles with en=1 and cs=0.
//  mpi_din is registered on the edge that leaves STROBE. No other sample point.
//  DONE is one cycle: cs=1, oe=0, rsp_valid=1, cmd_ready=1. It behaves as IDLE
//   for acceptance. Latency from accept to rsp_valid = S+E+H+1 cycles.
//  Back-to-back: a command accepted in DONE starts SETUP on the next cycle.
//   This guarantees at least one cs-high cycle between transactions.
//  cmd_ready=0 from SETUP through HOLD. cmd_valid during that time is ignored;
//   the source holds it.
//  Bus fields are latched at accept. cmd_* changes after accept have no effect.
//  After a write, mpi_addr and mpi_dout keep their last values. They are not cleared.
//  Reset mid-transaction: outputs return to reset values immediately and no
//   rsp_valid is produced.
// CONFIGURATION
//  MPI_MASTER_WRVERIFY_EN defined: after a write's HOLD, spend one cs-high
//   cycle, then run an automatic read of the same address (SETUP/STROBE/HOLD).
//   rsp_valid fires after that read. rsp_err=(readback!=wdata).
//   rsp_rdata=readback. Write latency = 2*(S+E+H)+2. Reads are unchanged.
//  MPI_MASTER_WRVERIFY_EN undefined: no verify states. rsp_err is tied to 0.
// STRUCTURE
//  Shared package mpi_pkg: MPI_AW=25, MPI_DW=16, state enum mpi_mst_st_t
//   {IDLE,SETUP,STROBE,HOLD,GAP,DONE}, and bus polarity constants (CS_ACT=0,
//   EN_ACT=0, RDWR_RD=1).
//  One sub-module, mpi_phase_cnt: loadable 4-bit down-counter with a zero flag.
//   It is reused for every phase.
// TESTING
//  Write 0x0001234<-0xBEEF, defaults -> cs low 7 cycles, en low 4 cycles,
//   oe=1, rsp_valid 8 cycles after accept, rsp_rdata=0.
//  Read 0x1FFFFFF, slave returns 0x5A5A on last strobe cycle -> rsp_rdata=0x5A5A.
//   Changing mpi_din one cycle earlier must not alter the result.
//  cmd_valid held high for 3 commands -> accepts only in IDLE/DONE.
//   Exactly 1 cs-high cycle between the transactions, 3 rsp pulses in order.
//  Assert rst during STROBE -> cs=1, en=1, oe=0 at once. No rsp_valid.
//   The next command after release completes normally.
//  SETUP=1, STROBE=1, HOLD=1 -> read latency 4 cycles, en low exactly 1 cycle.
//  With MPI_MASTER_WRVERIFY_EN: write 0x00FF, slave returns 0x00FE -> a second
//   cs cycle with rdwr=1, rsp_err=1, rsp_rdata=0x00FE, latency 16 with defaults.

Source files
------------

// File: rtl/mpi_pkg.sv
// Shared definitions for the MPI CPU-bus initiator: bus widths, master FSM
// states, bus polarity constants and small phase helpers.
package mpi_pkg;

    localparam int MPI_AW = 25;
    localparam int MPI_DW = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        GAP,
        DONE
    } mpi_mst_st_t;

    localparam logic CS_ACT  = 1'b0;
    localparam logic EN_ACT  = 1'b0;
    localparam logic RDWR_RD = 1'b1;

    // Phase counter preload: a phase of N cycles counts N-1 down to zero.
    function automatic logic [3:0] phase_load(input int cyc);
        return 4'(cyc - 1);
    endfunction

    // States during which the slave is selected.
    function automatic logic is_bus(input mpi_mst_st_t st);
        return (st == SETUP) || (st == STROBE) || (st == HOLD);
    endfunction

endpackage

// File: rtl/mpi_phase_cnt.sv
// Loadable 4-bit down-counter with zero flag; times every bus phase of the
// MPI master. Load has priority over decrement; it saturates at zero.
module mpi_phase_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/mpi_master.sv
// Initiator end of the MPI CPU bus: valid/ready commands become timed cs/strobe
// cycles. Optional write-verify readback is enabled by MPI_MASTER_WRVERIFY_EN.
module mpi_master
    import mpi_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk100m,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rd,
    input  logic [MPI_AW-1:0] cmd_addr,
    input  logic [MPI_DW-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [MPI_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mpi_cs,
    output logic              mpi_en,
    output logic              mpi_rdwr,
    output logic [MPI_AW-1:0] mpi_addr,
    output logic [MPI_DW-1:0] mpi_dout,
    output logic              mpi_oe,
    input  logic [MPI_DW-1:0] mpi_din
);

    localparam logic [3:0] SETUP_LD  = phase_load(SETUP_CYC);
    localparam logic [3:0] STROBE_LD = phase_load(STROBE_CYC);
    localparam logic [3:0] HOLD_LD   = phase_load(HOLD_CYC);

    mpi_mst_st_t       state, state_nxt;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [3:0]        cnt_val;
    logic              accept, sample;
    logic              rd_q;
    logic [MPI_DW-1:0] din_q;
`ifdef MPI_MASTER_WRVERIFY_EN
    logic              verify_q, verify_start;
`endif

    mpi_phase_cnt u_phase_cnt (
        .clk     (clk100m),
        .rst_n   (rst),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        accept    = 1'b0;
`ifdef MPI_MASTER_WRVERIFY_EN
        verify_start = 1'b0;
`endif
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                    cnt_load  = 1'b1;
                    cnt_val   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_nxt = STROBE;
                    cnt_load  = 1'b1;
                    cnt_val   = STROBE_LD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            STROBE: begin
                if (cnt_zero) begin
                    state_nxt = HOLD;
                    cnt_load  = 1'b1;
                    cnt_val   = HOLD_LD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
`ifdef MPI_MASTER_WRVERIFY_EN
                    state_nxt = (!rd_q && !verify_q) ? GAP : DONE;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    cnt_dec = 1'b1;
                end
            end
`ifdef MPI_MASTER_WRVERIFY_EN
            GAP: begin
                state_nxt    = SETUP;
                cnt_load     = 1'b1;
                cnt_val      = SETUP_LD;
                verify_start = 1'b1;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // The slave's data is taken only on the edge that ends the strobe.
    assign sample = (state == STROBE) && cnt_zero;

    // Outputs are registered from the next state so the bus sees clean edges.
    always_ff @(posedge clk100m or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rd_q      <= 1'b0;
            din_q     <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mpi_cs    <= ~CS_ACT;
            mpi_en    <= ~EN_ACT;
            mpi_rdwr  <= RDWR_RD;
            mpi_addr  <= '0;
            mpi_dout  <= '0;
            mpi_oe    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == IDLE) || (state_nxt == DONE);
            rsp_valid <= (state_nxt == DONE);
            mpi_cs    <= is_bus(state_nxt) ? CS_ACT : ~CS_ACT;
            mpi_en    <= (state_nxt == STROBE) ? EN_ACT : ~EN_ACT;
            if (accept) begin
                rd_q     <= cmd_rd;
                mpi_rdwr <= cmd_rd;
                mpi_addr <= cmd_addr;
                mpi_dout <= cmd_wdata;
                mpi_oe   <= ~cmd_rd;
            end else if (!is_bus(state_nxt)) begin
                mpi_oe   <= 1'b0;
            end
            if (sample) begin
                din_q <= mpi_din;
            end
`ifdef MPI_MASTER_WRVERIFY_EN
            if (verify_start) begin
                mpi_rdwr <= RDWR_RD;
            end
            if (state_nxt == DONE) begin
                rsp_rdata <= (rd_q || verify_q) ? din_q : '0;
            end
`else
            if (state_nxt == DONE) begin
                rsp_rdata <= rd_q ? din_q : '0;
            end
`endif
        end
    end

`ifdef MPI_MASTER_WRVERIFY_EN
    always_ff @(posedge clk100m or negedge rst) begin
        if (!rst) begin
            verify_q <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                verify_q <= 1'b0;
            end else if (verify_start) begin
                verify_q <= 1'b1;
            end
            if (state_nxt == DONE) begin
                rsp_err <= verify_q && (din_q != mpi_dout);
            end
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mpi_master.sv
// Self-checking bench for mpi_master: randomized and directed commands checked
// against a cycle-timeline model of the bus protocol built from S/E/H counts.
module tb_mpi_master;

    localparam int S = 2, E = 4, H = 1, P = S + E + H;
`ifdef MPI_MASTER_WRVERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic clk100m = 1'b0;
    logic rst     = 1'b0;
    always #5 clk100m = ~clk100m;

    logic        cmd_valid, cmd_ready, cmd_rd;
    logic [24:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic        mpi_cs, mpi_en, mpi_rdwr, mpi_oe;
    logic [24:0] mpi_addr;
    logic [15:0] mpi_dout, mpi_din;

    logic        b_cmd_valid, b_cmd_ready, b_cmd_rd;
    logic [24:0] b_cmd_addr;
    logic [15:0] b_cmd_wdata;
    logic        b_rsp_valid, b_rsp_err;
    logic [15:0] b_rsp_rdata;
    logic        b_mpi_cs, b_mpi_en, b_mpi_rdwr, b_mpi_oe;
    logic [24:0] b_mpi_addr;
    logic [15:0] b_mpi_dout, b_mpi_din;

    int vectors    = 0;
    int miscompares = 0;

    mpi_master #(.SETUP_CYC(S), .STROBE_CYC(E), .HOLD_CYC(H)) dut (
        .clk100m(clk100m), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mpi_cs(mpi_cs), .mpi_en(mpi_en), .mpi_rdwr(mpi_rdwr),
        .mpi_addr(mpi_addr), .mpi_dout(mpi_dout), .mpi_oe(mpi_oe),
        .mpi_din(mpi_din)
    );

    mpi_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_fast (
        .clk100m(clk100m), .rst(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_rd(b_cmd_rd),
        .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mpi_cs(b_mpi_cs), .mpi_en(b_mpi_en), .mpi_rdwr(b_mpi_rdwr),
        .mpi_addr(b_mpi_addr), .mpi_dout(b_mpi_dout), .mpi_oe(b_mpi_oe),
        .mpi_din(b_mpi_din)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transaction on the default-timed DUT. Caller is at a negedge.
    // The model: each pass is P selected cycles followed by one cs-high cycle
    // (gap before the verify read, or the response cycle).
    task automatic do_txn(input bit rd, input logic [24:0] addr, input logic [15:0] wd,
                          input logic [15:0] sd, input bit keep_valid, input string tag,
                          output int waited);
        int passes, len, pi, j;
        bit bus, rd_pass;
        logic [5:0] exp_v, got_v;
        logic [15:0] exp_rdata;
        logic exp_err;
        cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = addr; cmd_wdata = wd;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk100m);
            waited++;
        end
        if (!cmd_ready) begin
            vectors++; miscompares++;
            $display("FAIL %s accept: cmd_ready=%b required 1 within 50 cycles", tag, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk100m);
        cmd_valid = keep_valid;
        cmd_rd = 1'($urandom); cmd_addr = 25'($urandom); cmd_wdata = 16'($urandom);
        passes = (VERIFY && !rd) ? 2 : 1;
        len = passes * (P + 1);
        for (int k = 1; k <= len; k++) begin
            if (k > 1) @(negedge clk100m);
            pi  = (k - 1) / (P + 1);
            j   = k - pi * (P + 1);
            bus = (j <= P);
            rd_pass = rd || (pi == 1);
            exp_v = {~bus, !(j > S && j <= S + E), bus && pi == 0 && !rd,
                     bus ? rd_pass : mpi_rdwr, k == len, k == len};
            got_v = {mpi_cs, mpi_en, mpi_oe, mpi_rdwr, rsp_valid, cmd_ready};
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s cycle %0d {cs,en,oe,rdwr,rsp_valid,ready}: got %b required %b",
                         tag, k, got_v, exp_v);
            end
            if (bus) begin
                vectors++;
                if (mpi_addr !== addr || (!rd && mpi_dout !== wd)) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d addr/dout: got %h/%h required %h/%h",
                             tag, k, mpi_addr, mpi_dout, addr, wd);
                end
            end
            mpi_din = (bus && j == S + E && rd_pass) ? sd : sd ^ 16'($urandom_range(1, 65535));
            if (k == len) begin
                exp_rdata = (rd || VERIFY) ? sd : 16'h0;
                exp_err   = VERIFY && !rd && (sd != wd);
                vectors++;
                if (rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
                    miscompares++;
                    $display("FAIL %s response rdata/err: got %h/%b required %h/%b",
                             tag, rsp_rdata, rsp_err, exp_rdata, exp_err);
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [63:0] got, exp;
        @(negedge clk100m);
        got = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, mpi_cs, mpi_en, mpi_rdwr, mpi_oe,
               mpi_addr, mpi_dout};
        exp = {1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 25'h0, 16'h0};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_state: got %h required %h", got, exp);
        end
        vectors++;
        if ({b_cmd_ready, b_mpi_cs, b_mpi_en, b_mpi_oe, b_rsp_valid} !== 5'b11100) begin
            miscompares++;
            $display("FAIL reset_state_fast: got %b required 11100",
                     {b_cmd_ready, b_mpi_cs, b_mpi_en, b_mpi_oe, b_rsp_valid});
        end
        rst = 1'b1;
        @(negedge clk100m);
    endtask

    task automatic test_write;
        int w;
        do_txn(1'b0, 25'h0001234, 16'hBEEF, 16'hBEEF, 1'b0, "write", w);
        repeat (2) @(negedge clk100m);
        vectors++;
        if (mpi_addr !== 25'h0001234 || mpi_dout !== 16'hBEEF || mpi_cs !== 1'b1) begin
            miscompares++;
            $display("FAIL write_retain addr/dout/cs: got %h/%h/%b required 0001234/beef/1",
                     mpi_addr, mpi_dout, mpi_cs);
        end
    endtask

    task automatic test_read;
        int w;
        do_txn(1'b1, 25'h1FFFFFF, 16'h0, 16'h5A5A, 1'b0, "read", w);
    endtask

    task automatic test_back_to_back;
        int w;
        logic [15:0] sd [3];
        for (int i = 0; i < 3; i++) sd[i] = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            do_txn(1'b1, 25'($urandom), 16'h0, sd[i], 1'b1, $sformatf("b2b%0d", i), w);
            if (i > 0) begin
                vectors++;
                if (w != 0) begin
                    miscompares++;
                    $display("FAIL b2b%0d accept_wait: got %0d required 0", i, w);
                end
            end
        end
        cmd_valid = 1'b0;
        @(negedge clk100m);
    endtask

    task automatic test_reset_mid;
        int w;
        logic [4:0] got;
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 25'h0ABCDEF; cmd_wdata = 16'h1357;
        @(negedge clk100m);
        cmd_valid = 1'b0;
        repeat (S + 1) @(negedge clk100m);
        rst = 1'b0;
        #1;
        got = {mpi_cs, mpi_en, mpi_oe, rsp_valid, cmd_ready};
        vectors++;
        if (got !== 5'b11001) begin
            miscompares++;
            $display("FAIL reset_mid {cs,en,oe,rsp_valid,ready}: got %b required 11001", got);
        end
        @(negedge clk100m);
        rst = 1'b1;
        for (int k = 0; k < P + 3; k++) begin
            @(negedge clk100m);
            vectors++;
            if (rsp_valid !== 1'b0 || mpi_cs !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_mid_quiet cycle %0d rsp_valid/cs: got %b/%b required 0/1",
                         k, rsp_valid, mpi_cs);
            end
        end
        do_txn(1'b1, 25'h0000042, 16'h0, 16'hC0DE, 1'b0, "after_reset", w);
    endtask

    task automatic test_fast_timing;
        int lat, en_low, waited;
        logic [15:0] sd;
        sd = 16'($urandom);
        b_cmd_valid = 1'b1; b_cmd_rd = 1'b1; b_cmd_addr = 25'($urandom);
        waited = 0;
        while (!b_cmd_ready && waited < 50) begin
            @(negedge clk100m);
            waited++;
        end
        @(negedge clk100m);
        b_cmd_valid = 1'b0;
        lat = 0; en_low = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk100m);
            if (!b_mpi_en) en_low++;
            b_mpi_din = !b_mpi_en ? sd : ~sd;
            if (b_rsp_valid) begin
                lat = k;
                break;
            end
        end
        vectors++;
        if (lat != 4 || en_low != 1 || b_rsp_rdata !== sd) begin
            miscompares++;
            $display("FAIL fast_read latency/en_low/rdata: got %0d/%0d/%h required 4/1/%h",
                     lat, en_low, b_rsp_rdata, sd);
        end
    endtask

    task automatic test_verify;
        int w;
        do_txn(1'b0, 25'h0000100, 16'h00FF, 16'h00FE, 1'b0, "wr_verify", w);
    endtask

    task automatic test_random;
        int w;
        logic [15:0] wd;
        for (int i = 0; i < 16; i++) begin
            wd = 16'($urandom);
            do_txn(1'($urandom), 25'($urandom), wd,
                   ($urandom_range(0, 1) == 1) ? wd : 16'($urandom),
                   1'($urandom), $sformatf("rand%0d", i), w);
        end
        cmd_valid = 1'b0;
        @(negedge clk100m);
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = '0; cmd_wdata = '0; mpi_din = '0;
        b_cmd_valid = 1'b0; b_cmd_rd = 1'b0; b_cmd_addr = '0; b_cmd_wdata = '0; b_mpi_din = '0;
        repeat (2) @(negedge clk100m);
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_fast_timing();
        test_verify();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
